// File: rtl/note_sequencer.sv
// note_sequencer: turns a byte command stream (note letters, rests, length
// digits, '!' abort) into a queue of notes and plays them one at a time on
// the tone generator's freq/duration/done interface, with a silent gap
// between notes.
// Optional build macro: NOTE_SEQUENCER_OCTAVE_EN adds '<' / '>' octave shifts.
module note_sequencer #(
    parameter int FIFO_AW     = 4,
    parameter int BEAT_MS     = 100,
    parameter int DEFAULT_LEN = 4,
    parameter int CLK_HZ      = 48000000,
    parameter int GAP_CYCLES  = 48000
) (
    input  logic               clk_48mhz,
    input  logic               reset,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    input  logic               tone_done,
    output logic [31:0]        freq,
    output logic [31:0]        duration,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);
    localparam int DEPTH       = 1 << FIFO_AW;
    localparam int TICK_CYCLES = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
`ifdef NOTE_SEQUENCER_OCTAVE_EN
    localparam int ENTRY_W = 10;   // {octave, rest, idx, len}
`else
    localparam int ENTRY_W = 8;    // {rest, idx, len}
`endif

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_REST, ST_GAP} state_t;

    state_t               state_reg, state_next;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [ENTRY_W-1:0]   entry_in, entry_reg;
    logic [FIFO_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]     fifo_count_reg;
    logic [3:0]           cur_len_reg;
    logic [31:0]          freq_reg, duration_reg, ms_reg, tick_cnt_reg, gap_cnt_reg;
    logic                 is_note, is_rest, is_len, is_flush;
    logic [2:0]           note_idx;
    logic                 accept, push, pop, flush, tick;
    logic                 ld_rest;
    logic [2:0]           ld_idx;
    logic [3:0]           ld_len;
    logic [1:0]           ld_oct;
    logic [31:0]          ld_ms;

    function automatic logic [31:0] note_hz(input logic [2:0] idx);
        case (idx)
            3'd0:    note_hz = 32'd262;
            3'd1:    note_hz = 32'd294;
            3'd2:    note_hz = 32'd330;
            3'd3:    note_hz = 32'd349;
            3'd4:    note_hz = 32'd392;
            3'd5:    note_hz = 32'd440;
            3'd6:    note_hz = 32'd494;
            default: note_hz = 32'd523;
        endcase
    endfunction

    // Classify the incoming byte; only accepted bytes have any effect.
    always_comb begin
        is_note  = 1'b1;
        note_idx = 3'd0;
        case (byte_data)
            "C":     note_idx = 3'd0;
            "D":     note_idx = 3'd1;
            "E":     note_idx = 3'd2;
            "F":     note_idx = 3'd3;
            "G":     note_idx = 3'd4;
            "A":     note_idx = 3'd5;
            "B":     note_idx = 3'd6;
            "c":     note_idx = 3'd7;
            default: is_note  = 1'b0;
        endcase
        is_rest  = (byte_data == "-");
        is_len   = (byte_data >= "1") && (byte_data <= "8");
        is_flush = (byte_data == "!");
    end

    // Reset is folded in so nothing is consumed while reset is held.
    assign byte_ready = (fifo_count_reg != (FIFO_AW + 1)'(DEPTH)) && !reset;
    assign accept     = byte_valid && byte_ready;
    assign push       = accept && (is_note || is_rest);
    assign flush      = accept && is_flush;

    assign entry_in[7:0] = {is_rest, note_idx, cur_len_reg};
`ifdef NOTE_SEQUENCER_OCTAVE_EN
    logic [1:0] octave_reg;
    assign entry_in[9:8] = octave_reg;
    assign ld_oct        = entry_reg[9:8];

    // Octave register, saturating in 0..2; untouched by '!'.
    always_ff @(posedge clk_48mhz) begin
        if (reset)
            octave_reg <= 2'd0;
        else if (accept && byte_data == ">" && octave_reg < 2'd2)
            octave_reg <= octave_reg + 2'd1;
        else if (accept && byte_data == "<" && octave_reg > 2'd0)
            octave_reg <= octave_reg - 2'd1;
    end
`else
    assign ld_oct = 2'd0;
`endif

    assign ld_rest = entry_reg[7];
    assign ld_idx  = entry_reg[6:4];
    assign ld_len  = entry_reg[3:0];
    assign ld_ms   = 32'(ld_len) * 32'(BEAT_MS);
    assign tick    = (tick_cnt_reg == 32'(TICK_CYCLES - 1));

    // Sticky note length set by digit bytes; '!' leaves it alone.
    always_ff @(posedge clk_48mhz) begin
        if (reset)
            cur_len_reg <= 4'(DEFAULT_LEN);
        else if (accept && is_len)
            cur_len_reg <= byte_data[3:0];
    end

    // Note storage without reset; the popped entry is registered for LOAD.
    always_ff @(posedge clk_48mhz) begin
        if (push)
            mem[wr_ptr_reg] <= entry_in;
        if (pop)
            entry_reg <= mem[rd_ptr_reg];
    end

    // FIFO pointers and occupancy; flush empties by catching up the read side.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else if (flush) begin
            rd_ptr_reg     <= wr_ptr_reg;
            fifo_count_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            fifo_count_reg <= fifo_count_reg + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        end
    end

    // Player state register.
    always_ff @(posedge clk_48mhz) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Player next-state and pop decision; an abort always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (fifo_count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = ST_LOAD;
                end
                ST_LOAD: state_next = ld_rest ? ST_REST : ST_WAIT;
                ST_WAIT: if (tone_done) state_next = ST_GAP;
                ST_REST: if (tick && ms_reg <= 32'd1) state_next = ST_GAP;
                ST_GAP:  if (gap_cnt_reg + 32'd1 >= 32'(GAP_CYCLES)) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Tone outputs, rest millisecond timer and gap counter.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            freq_reg     <= '0;
            duration_reg <= '0;
            ms_reg       <= '0;
            tick_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
        end else begin
            tick_cnt_reg <= (state_reg == ST_REST && !tick) ? tick_cnt_reg + 32'd1 : 32'd0;
            gap_cnt_reg  <= (state_reg == ST_GAP) ? gap_cnt_reg + 32'd1 : 32'd0;
            if (flush) begin
                duration_reg <= '0;
            end else begin
                case (state_reg)
                    ST_LOAD: begin
                        if (ld_rest) begin
                            freq_reg     <= '0;
                            duration_reg <= '0;
                            ms_reg       <= ld_ms;
                        end else begin
                            freq_reg     <= note_hz(ld_idx) << ld_oct;
                            duration_reg <= ld_ms;
                        end
                    end
                    ST_WAIT: if (tone_done) duration_reg <= '0;
                    ST_REST: if (tick) ms_reg <= ms_reg - 32'd1;
                    default: ;
                endcase
            end
        end
    end

    assign freq       = freq_reg;
    assign duration   = duration_reg;
    assign fifo_count = fifo_count_reg;
    assign busy       = (fifo_count_reg != '0) || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenarios plus a randomized byte stream, with a
// queue-based reference model compared against the DUT on every cycle.
`timescale 1ns/1ps
module tb_note_sequencer;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int BEAT  = 100;
    localparam int DLEN  = 4;
    localparam int CLKHZ = 1000;
    localparam int GAP   = 5;
    localparam int TICK  = CLKHZ / 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        tone_done = 1'b0;
    logic        byte_ready, busy;
    logic [31:0] freq, duration;
    logic [AW:0] fifo_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit auto_done = 1'b0;
    int max_count = 0;

    note_sequencer #(
        .FIFO_AW(AW), .BEAT_MS(BEAT), .DEFAULT_LEN(DLEN), .CLK_HZ(CLKHZ), .GAP_CYCLES(GAP)
    ) dut (
        .clk_48mhz(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .tone_done(tone_done), .freq(freq), .duration(duration),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit rest; int hz; int len; } note_t;
    note_t q[$];
    note_t cur;
    int m_len = DLEN, m_oct = 0, m_silence = 0;
    bit m_loading = 0, m_tone = 0;
    int exp_freq = 0, exp_dur = 0;

    function automatic int hz_of(input logic [7:0] c);
        case (c)
            "C": return 262;  "D": return 294;  "E": return 330;  "F": return 349;
            "G": return 392;  "A": return 440;  "B": return 494;  "c": return 523;
            default: return 0;
        endcase
    endfunction

    // The player is either loading a popped note, sounding a tone until done,
    // or silent for a known number of cycles (rest time plus gap); else idle.
    always @(posedge clk) begin : model
        bit acc;
        note_t n;
        acc = byte_valid && !reset && (q.size() < DEPTH);
        if (reset) begin
            q.delete();
            exp_freq = 0; exp_dur = 0; m_len = DLEN; m_oct = 0;
            m_silence = 0; m_loading = 0; m_tone = 0;
        end else if (acc && byte_data == "!") begin
            q.delete();
            exp_dur = 0; m_silence = 0; m_loading = 0; m_tone = 0;
        end else begin
            if (m_silence > 0) begin
                m_silence--;
            end else if (m_tone) begin
                if (tone_done) begin
                    exp_dur = 0; m_tone = 0; m_silence = GAP;
                end
            end else if (m_loading) begin
                m_loading = 0;
                if (cur.rest) begin
                    exp_freq = 0; exp_dur = 0; m_silence = cur.len * BEAT * TICK + GAP;
                end else begin
                    exp_freq = cur.hz; exp_dur = cur.len * BEAT; m_tone = 1;
                end
            end else if (q.size() > 0) begin
                cur = q.pop_front();
                m_loading = 1;
            end
            if (acc) begin
                if (hz_of(byte_data) != 0) begin
                    n.rest = 0; n.hz = hz_of(byte_data) << m_oct; n.len = m_len;
                    q.push_back(n);
                end else if (byte_data == "-") begin
                    n.rest = 1; n.hz = 0; n.len = m_len;
                    q.push_back(n);
                end else if (byte_data >= "1" && byte_data <= "8") begin
                    m_len = int'(byte_data) - int'("0");
                end
`ifdef NOTE_SEQUENCER_OCTAVE_EN
                else if (byte_data == ">" && m_oct < 2) m_oct++;
                else if (byte_data == "<" && m_oct > 0) m_oct--;
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("freq", freq, exp_freq);
            check("duration", duration, exp_dur);
            check("fifo_count", fifo_count, q.size());
            check("busy", busy, (q.size() != 0) || m_loading || m_tone || (m_silence > 0));
            check("byte_ready", byte_ready, !reset && (q.size() < DEPTH));
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        end
    end

    // Random tone_done when enabled; otherwise the main process owns it.
    initial forever begin
        @(posedge clk); #1;
        if (auto_done) tone_done = ($urandom_range(0, 7) == 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            n++;
            if (n > 5000) begin
                vectors++; miscompares++;
                $display("FAIL send_byte timeout: byte %0d never accepted", b);
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin @(negedge clk); n++; end
        if (n >= bound) begin
            vectors++; miscompares++;
            $display("FAIL wait_idle timeout: busy %0d after %0d cycles", busy, n);
        end
        step(1);
    endtask

    task automatic wait_sounding(input int bound);
        int n = 0;
        while (duration == 32'd0 && n < bound) begin @(negedge clk); n++; end
        if (n >= bound) begin
            vectors++; miscompares++;
            $display("FAIL wait_sounding timeout: duration %0d", duration);
        end
        step(1);
    endtask

    string cs = "CDEFGABc-12345678!xz<>Q";

    initial begin
        step(1);
        chk_en = 1'b1;
        step(2);
        reset = 1'b0;
        #1;
        check("reset_freq", freq, 0);
        check("reset_duration", duration, 0);
        check("reset_count", fifo_count, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", byte_ready, 1);
        step(1);

        // Single note: latency, done handling, gap length.
        send_byte("A");
        step(1);
        check("a_before_load", duration, 0);
        step(1);
        check("a_freq", freq, 440);
        check("a_duration", duration, 400);
        step(9);
        tone_done = 1'b1;
        step(1);
        tone_done = 1'b0;
        check("a_done_duration", duration, 0);
        step(GAP);
        check("a_idle_busy", busy, 0);

        // Sticky length and a rest between two notes.
        auto_done = 1'b1;
        send_str("2C-E");
        wait_idle(20000);
        check("ce_last_freq", freq, 330);

        // Fill the FIFO with the player stalled in WAIT.
        auto_done = 1'b0;
        tone_done = 1'b0;
        for (int i = 0; i < 17; i++) send_byte("G");
        check("full_count", fifo_count, 16);
        check("full_ready", byte_ready, 0);
        byte_valid = 1'b1;
        byte_data  = "E";
        step(20);
        check("held_ready", byte_ready, 0);
        tone_done = 1'b1;
        step(1);
        tone_done = 1'b0;
        send_byte("E");
        check("held_count", fifo_count, 16);
        auto_done = 1'b1;
        wait_idle(20000);
        check("max_count", max_count, 16);

        // Push coinciding with an IDLE pop at count 3.
        auto_done = 1'b0;
        tone_done = 1'b0;
        send_str("ABCD");
        step(3);
        check("pp_count_before", fifo_count, 3);
        tone_done = 1'b1;
        step(1);
        tone_done = 1'b0;
        step(GAP);
        byte_valid = 1'b1;
        byte_data  = "c";
        step(1);
        byte_valid = 1'b0;
        check("pp_count_after", fifo_count, 3);
        auto_done = 1'b1;
        wait_idle(20000);
        check("pp_last_freq", freq, 523);

        // Abort during WAIT, then play again.
        auto_done = 1'b0;
        tone_done = 1'b0;
        send_str("ABC");
        wait_sounding(100);
        send_byte("!");
        check("flush_duration", duration, 0);
        check("flush_count", fifo_count, 0);
        check("flush_busy", busy, 0);
        send_byte("D");
        step(2);
        check("flush_d_freq", freq, 294);
        auto_done = 1'b1;
        wait_idle(20000);

        // Reset in the middle of a note.
        auto_done = 1'b0;
        tone_done = 1'b0;
        send_str("7EFG");
        wait_sounding(100);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_duration", duration, 0);
        check("rst_freq", freq, 0);
        check("rst_count", fifo_count, 0);
        send_byte("A");
        step(2);
        check("rst_len_default", duration, 400);
        auto_done = 1'b1;
        wait_idle(20000);

`ifdef NOTE_SEQUENCER_OCTAVE_EN
        send_str(">>>A");
        wait_sounding(100);
        check("octave_freq", freq, 1760);
        wait_idle(20000);
        send_str("<<<");
`endif

        // Randomized command stream with random done timing and rare resets.
        for (int i = 0; i < 250; i++) begin
            step($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end
            send_byte(8'(cs[$urandom_range(0, cs.len() - 1)]));
        end
        wait_idle(30000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
